pattern_scheduler: RTL
======================

Name: pattern_scheduler

Overview:
Frame-synchronous controller that sequences the hardware test-pattern generator on the VGA output path. It sits between the vga_controller and the pattern generator. It selects which pattern is shown and supplies the per-frame animation phase. Pattern and phase change only at the start of vertical active video, so no frame ever shows two patterns (no tearing). It supports auto-cycling, a pause, and a single-step request from board buttons.

Parameters:
NUM_PATTERNS, 4, number of selectable patterns (1..8); pattern_sel wraps at NUM_PATTERNS-1
DWELL_FRAMES, 180, frames each pattern is shown in auto mode (1..65535)
PHASE_MAX, 179, last value of the phase counter before it wraps to 0 (0..255)

Ports:
pixel_clk  in   1  25 MHz pixel clock; the only clock
rst        in   1  asynchronous, active-high reset
vact       in   1  vertical-active level from vga_controller, synchronous to pixel_clk
auto_en    in   1  1 = advance pattern every DWELL_FRAMES frames; level, synchronous
step_btn   in   1  step request, raw button level, asynchronous
pause_btn  in   1  pause toggle, raw button level, asynchronous
pattern_sel out 3  current pattern index 0..NUM_PATTERNS-1
phase      out  8  per-frame animation phase 0..PHASE_MAX
frame_start out 1  one-cycle pulse marking the first cycle of a new active frame
paused     out  1  1 = phase and dwell counting are frozen

Behaviour:
- Reset (asynchronous, active-high) drives every register to its reset value:
  - pattern_sel=0, phase=0, frame_start=0, paused=0.
  - Dwell counter=0, step_pend=0, pause_pend=0.
  - Synchronizer flops=0.
  - vact_d=1, so no spurious frame_start occurs if vact is already high when reset releases.
- Button conditioning:
  - Each button passes through a 2-flop synchronizer, then a rising-edge detect.
  - A request registers in the pending flag 3 pixel_clk edges after the button rises.
  - Buttons are assumed debounced externally.
- Frame edge: fs = vact & ~vact_d, where vact_d is vact registered one cycle.
  - frame_start is fs registered, so it is high for exactly one cycle.
  - pattern_sel, phase and paused update on the same clock edge that sets frame_start=1.
- Pending flags:
  - step_pend sets on a step edge and clears at the next fs.
  - pause_pend toggles-request likewise.
  - Multiple edges within one frame collapse into a single request.
- State machine, states RUN and PAUSE, evaluated only at fs:
  - RUN: phase = (phase==PHASE_MAX) ? 0 : phase+1.
    - If auto_en=1: dwell+1; when dwell==DWELL_FRAMES-1, advance the pattern.
    - If auto_en=0: dwell is held at 0.
  - PAUSE: phase and dwell hold.
  - RUN->PAUSE or PAUSE->RUN happens when pause_pend=1. The new state takes effect at this fs; the counter update at this fs uses the old state.
- Advance: pattern_sel = (pattern_sel==NUM_PATTERNS-1) ? 0 : pattern_sel+1; dwell=0; phase=0.
  - An advance overrides the phase increment.
- Step: step_pend at fs forces one advance in either state.
  - If a step and a dwell expiry coincide, the pattern advances once only.
- Simultaneous step and pause at one fs: the advance occurs and the state toggles.
- Outside fs, all outputs except frame_start hold.
- Changes to auto_en mid-frame take effect at the next fs.
- Reset asserted mid-frame: outputs return to reset values immediately. The first frame_start follows the next 0->1 transition of vact.
- Widths: the dwell counter is 16 bits. All wraps use explicit compares, never modulo on the natural width.

Test Plan:
- Reset release with vact=1, then 3 frames → no frame_start until vact falls and rises; then phase 1,2,3 and pattern_sel=0.
- auto_en=1, DWELL_FRAMES=4, NUM_PATTERNS=3, 14 frames → pattern_sel sequence 0,0,0,1,1,1,1,2,2,2,2,0…; phase resets to 0 at each change.
- PHASE_MAX=179, auto_en=0, 181 frames → phase reaches 179 then 0 then 1; pattern_sel stays 0.
- Pause pulse mid-frame → at the next fs, phase increments once more, paused=1; the following 5 frames hold phase. A second pulse resumes counting.
- Three step pulses within one frame while paused → exactly one advance at the next fs; phase=0; paused stays 1.
- Step pulse in the frame where dwell expires (DWELL_FRAMES=2) → pattern_sel +1 only; dwell=0. Reset asserted mid-frame → all outputs 0 asynchronously.

Source files
------------

// File: rtl/pattern_scheduler.sv
// Frame-synchronous sequencer for the VGA test-pattern generator: selects the
// pattern and animation phase, changing both only at the start of vertical active.
module pattern_scheduler #(
    parameter int NUM_PATTERNS = 4,
    parameter int DWELL_FRAMES = 180,
    parameter int PHASE_MAX    = 179
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       vact,
    input  logic       auto_en,
    input  logic       step_btn,
    input  logic       pause_btn,
    output logic [2:0] pattern_sel,
    output logic [7:0] phase,
    output logic       frame_start,
    output logic       paused
);

    localparam logic [2:0]  PAT_LAST   = 3'(NUM_PATTERNS - 1);
    localparam logic [15:0] DWELL_LAST = 16'(DWELL_FRAMES - 1);
    localparam logic [7:0]  PHASE_LAST = 8'(PHASE_MAX);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

    logic [1:0] btn_raw;
    logic [1:0] btn_edge;

    assign btn_raw = {pause_btn, step_btn};

    // Two-flop synchronizer plus rising-edge detect for each board button.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic meta_q;
            logic sync_q;
            logic prev_q;

            always_ff @(posedge pixel_clk or posedge rst) begin
                if (rst) begin
                    meta_q <= 1'b0;
                    sync_q <= 1'b0;
                    prev_q <= 1'b0;
                end else begin
                    meta_q <= btn_raw[gi];
                    sync_q <= meta_q;
                    prev_q <= sync_q;
                end
            end

            assign btn_edge[gi] = sync_q & ~prev_q;
        end
    endgenerate

    logic vact_d_q;
    logic fs;

    // vact_d resets high so a frame already in progress at release is ignored.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            vact_d_q <= 1'b1;
        end else begin
            vact_d_q <= vact;
        end
    end

    assign fs = vact & ~vact_d_q;

    logic step_pend_q;
    logic step_pend_d;
    logic pause_pend_q;
    logic pause_pend_d;

    always_comb begin
        step_pend_d  = (step_pend_q  & ~fs) | btn_edge[0];
        pause_pend_d = (pause_pend_q & ~fs) | btn_edge[1];
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            step_pend_q  <= 1'b0;
            pause_pend_q <= 1'b0;
        end else begin
            step_pend_q  <= step_pend_d;
            pause_pend_q <= pause_pend_d;
        end
    end

    state_t state_q;
    state_t state_d;

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (fs && pause_pend_q) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
    end

    always_comb begin
        paused = (state_q == ST_PAUSE);
    end

    logic [2:0]  pat_q;
    logic [2:0]  pat_d;
    logic [7:0]  phase_q;
    logic [7:0]  phase_d;
    logic [15:0] dwell_q;
    logic [15:0] dwell_d;
    logic        frame_start_q;
    logic        dwell_expired;
    logic        advance;

    // Counter update uses the state before any pause toggle at this fs.
    always_comb begin
        dwell_expired = (state_q == ST_RUN) && auto_en && (dwell_q == DWELL_LAST);
        advance       = fs && (step_pend_q || dwell_expired);
        pat_d         = pat_q;
        phase_d       = phase_q;
        dwell_d       = dwell_q;
        if (advance) begin
            pat_d   = (pat_q == PAT_LAST) ? 3'd0 : pat_q + 3'd1;
            phase_d = 8'd0;
            dwell_d = 16'd0;
        end else if (fs && (state_q == ST_RUN)) begin
            phase_d = (phase_q == PHASE_LAST) ? 8'd0 : phase_q + 8'd1;
            dwell_d = auto_en ? dwell_q + 16'd1 : 16'd0;
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            pat_q         <= 3'd0;
            phase_q       <= 8'd0;
            dwell_q       <= 16'd0;
            frame_start_q <= 1'b0;
        end else begin
            pat_q         <= pat_d;
            phase_q       <= phase_d;
            dwell_q       <= dwell_d;
            frame_start_q <= fs;
        end
    end

    assign pattern_sel = pat_q;
    assign phase       = phase_q;
    assign frame_start = frame_start_q;

endmodule
